popcnt_arbiter: RTL and testbench

Iterative, shared population-count engine that sums the set bits of a 32-bit word over several cycles. Two requesters share it through a round-robin arbiter. Results go back through a valid/ready response port tagged with the requester ID. It sits between the two word producers and any consumer that needs a per-word bit sum. It replaces a single-cycle 32-input adder tree with a narrow datapath that a controller sequences.

---
 rtl/popcnt_arbiter.sv | 119 +++++++++++
 tb/tb_popcnt_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/popcnt_arbiter.sv
// Shared iterative population-count engine: two requesters, round-robin arbitration,
// BITS_PER_CYCLE bits summed per COUNT cycle, result returned on a tagged valid/ready port.
module popcnt_arbiter #(
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [31:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_data,
  output logic        req1_ready,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [5:0]  resp_sum,
  output logic        busy
);

  localparam int N  = 32 / BITS_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [31:0]   sh, sh_shifted;
  logic [5:0]    acc, slice_ones;
  logic [CW-1:0] cnt;
  logic          id, last_grant, grant, accept;

  // Round-robin: a lone requester always wins, a tie goes to whoever did not win last.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign a default first so no latch is inferred.
    grant = ~last_grant;
    if (req0_valid && !req1_valid)
      grant = 1'b0;
    else if (req1_valid && !req0_valid)
      grant = 1'b1;
  end

  assign req0_ready = (state == IDLE) && !grant && req0_valid;
  assign req1_ready = (state == IDLE) &&  grant && req1_valid;
  assign accept     = req0_ready || req1_ready;

  always_comb begin
    slice_ones = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++)
      slice_ones = slice_ones + 6'(sh[i]);
  end

  // A full-width step empties the register in one go; a shift by 32 is avoided outright.
  generate
    if (BITS_PER_CYCLE == 32) begin : g_full
      assign sh_shifted = '0;
    end else begin : g_part
      assign sh_shifted = {{BITS_PER_CYCLE{1'b0}}, sh[31:BITS_PER_CYCLE]};
    end
  endgenerate

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept)            state_nxt = COUNT;
      COUNT:   if (cnt == CNT_LAST)   state_nxt = DONE;
      DONE:    if (resp_ready)        state_nxt = IDLE;
      default:                        state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state is updated with non-blocking '<=' so every register samples pre-edge values.
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh         <= '0;
      acc        <= '0;
      cnt        <= '0;
      id         <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            sh         <= grant ? req1_data : req0_data;
            id         <= grant;
            last_grant <= grant;
            acc        <= '0;
            cnt        <= '0;
          end
        end
        COUNT: begin
          acc <= acc + slice_ones;
          sh  <= sh_shifted;
          // Hold on the last step so a single-step configuration keeps cnt at zero.
          if (cnt != CNT_LAST)
            cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign resp_valid = (state == DONE);
  assign resp_sum   = resp_valid ? acc : '0;
  assign resp_id    = resp_valid & id;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_popcnt_arbiter.sv
// Scoreboard bench for popcnt_arbiter, run side by side for BITS_PER_CYCLE = 4, 1 and 32.
module tb_popcnt_arbiter;

  typedef struct {
    logic       id;
    logic [5:0] sum;
    int         due;
  } exp_t;

  logic clk;
  int   cyc;
  int   errors;
  int   checks;

  initial begin
    clk    = 1'b0;
    cyc    = 0;
    errors = 0;
    checks = 0;
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int BPC = (g == 0) ? 4 : (g == 1) ? 1 : 32;
    localparam int N   = 32 / BPC;

    logic        rst, r0v, r1v, r0r, r1r, rr, rv, rid, bsy, done;
    logic [31:0] r0d, r1d;
    logic [5:0]  rsum;

    // Reference model state: occupancy, tie-break owner and expected responses.
    bit   pending;
    bit   m_last;
    int   due;
    int   accept_count;
    int   busy_cnt;
    exp_t q[$];

    popcnt_arbiter #(.BITS_PER_CYCLE(BPC)) dut (
      .clk        (clk),
      .reset      (rst),
      .req0_valid (r0v),
      .req0_data  (r0d),
      .req0_ready (r0r),
      .req1_valid (r1v),
      .req1_data  (r1d),
      .req1_ready (r1r),
      .resp_valid (rv),
      .resp_ready (rr),
      .resp_id    (rid),
      .resp_sum   (rsum),
      .busy       (bsy)
    );

    // Model: predicts handshakes from the arbitration rules and queues expected results.
    always @(negedge clk) begin
      if (!rst) begin
        bit gnt, r0e, r1e;
        gnt = (r0v && r1v) ? ~m_last : r1v;
        r0e = !pending && r0v && !gnt;
        r1e = !pending && r1v &&  gnt;
        check($sformatf("bpc%0d req0_ready", BPC), r0r, r0e);
        check($sformatf("bpc%0d req1_ready", BPC), r1r, r1e);
        check($sformatf("bpc%0d busy", BPC), bsy, pending);
        check($sformatf("bpc%0d resp_valid", BPC), rv, pending && (cyc >= due));
        if (bsy) busy_cnt++;
        if (r0e || r1e) begin
          pending = 1'b1;
          due     = cyc + 1 + N;
          m_last  = gnt;
          q.push_back('{gnt, 6'($countones(gnt ? r1d : r0d)), cyc + 1 + N});
          accept_count++;
        end else if (pending && (cyc >= due) && rr) begin
          pending = 1'b0;
        end
      end
    end

    // Monitor: compares every presented response against the queue head.
    always @(negedge clk) begin
      if (!rst && rv) begin
        if (q.size() == 0) begin
          check($sformatf("bpc%0d unexpected response", BPC), rv, 1'b0);
        end else begin
          check($sformatf("bpc%0d resp_id", BPC), rid, q[0].id);
          check($sformatf("bpc%0d resp_sum", BPC), rsum, q[0].sum);
          if (rr) q.delete(0);
        end
      end
    end

    task automatic do_reset();
      r0v     = 1'b0;
      r1v     = 1'b0;
      rst     = 1'b1;
      pending = 1'b0;
      m_last  = 1'b1;
      q.delete();
      #1;
      check($sformatf("bpc%0d reset resp_valid", BPC), rv, 1'b0);
      check($sformatf("bpc%0d reset busy", BPC), bsy, 1'b0);
      check($sformatf("bpc%0d reset resp_sum", BPC), rsum, 6'd0);
      check($sformatf("bpc%0d reset resp_id", BPC), rid, 1'b0);
      check($sformatf("bpc%0d reset req0_ready", BPC), r0r, 1'b0);
      check($sformatf("bpc%0d reset req1_ready", BPC), r1r, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
    endtask

    // Offers a word and returns just after the accepting edge, scrambling the source word.
    task automatic send(input bit who, input logic [31:0] w);
      bit ok;
      ok = 1'b0;
      if (who) begin r1v = 1'b1; r1d = w; end
      else     begin r0v = 1'b1; r0d = w; end
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if ((who ? r1r : r0r) === 1'b1) begin
          ok = 1'b1;
          break;
        end
      end
      check($sformatf("bpc%0d accept within budget", BPC), ok, 1'b1);
      @(posedge clk);
      #1;
      if (who) begin r1v = 1'b0; r1d = $urandom; end
      else     begin r0v = 1'b0; r0d = $urandom; end
    endtask

    task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
        @(negedge clk);
        if (!bsy && !pending && q.size() == 0) begin
          ok = 1'b1;
          break;
        end
      end
      check($sformatf("bpc%0d drain within budget", BPC), ok, 1'b1);
      @(posedge clk);
      #1;
    endtask

    initial begin
      bit ok;
      int start;
      done         = 1'b0;
      r0d          = '0;
      r1d          = '0;
      rr           = 1'b1;
      accept_count = 0;
      busy_cnt     = 0;
      due          = 0;
      do_reset();

      // All-ones word: full sum, busy for N+1 cycles.
      busy_cnt = 0;
      send(1'b0, 32'hFFFF_FFFF);
      wait_idle();
      check($sformatf("bpc%0d busy cycles", BPC), busy_cnt, N + 1);

      // Back-to-back words from requester 1.
      send(1'b1, 32'h0000_0000);
      send(1'b1, 32'h8000_0001);
      wait_idle();

      // Both requesters valid continuously from reset: grants alternate starting with req0.
      do_reset();
      start = accept_count;
      r0v = 1'b1; r0d = 32'h0000_000F;
      r1v = 1'b1; r1d = 32'h0000_00FF;
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
        @(posedge clk);
        if (accept_count >= start + 4) begin
          ok = 1'b1;
          break;
        end
      end
      #1;
      r0v = 1'b0;
      r1v = 1'b0;
      check($sformatf("bpc%0d four grants within budget", BPC), ok, 1'b1);
      wait_idle();

      // Backpressure in DONE with req1 waiting.
      rr = 1'b0;
      send(1'b0, 32'h1234_5678);
      r1v = 1'b1;
      r1d = 32'hFFFF_0000;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (rv === 1'b1) begin
          ok = 1'b1;
          break;
        end
      end
      check($sformatf("bpc%0d resp_valid within budget", BPC), ok, 1'b1);
      repeat (5) @(posedge clk);
      #1 rr = 1'b1;
      send(1'b1, 32'hFFFF_0000);
      wait_idle();

      // Reset during an in-flight word, then a fresh word must start from zero.
      rr = 1'b0;
      send(1'b0, 32'hDEAD_BEEF);
      repeat (2) @(posedge clk);
      #1;
      do_reset();
      rr = 1'b1;
      send(1'b0, 32'h0000_0001);
      wait_idle();

      // Random traffic with valid dropping and random backpressure.
      for (int i = 0; i < 300; i++) begin
        @(posedge clk);
        #1;
        r0v = 1'($urandom_range(0, 1));
        r1v = 1'($urandom_range(0, 1));
        r0d = $urandom;
        r1d = $urandom;
        rr  = ($urandom_range(0, 3) != 0);
      end
      r0v = 1'b0;
      r1v = 1'b0;
      rr  = 1'b1;
      wait_idle();
      done = 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    wait (g_inst[0].done && g_inst[1].done && g_inst[2].done);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
